// File: rtl/xts_tweak_engine.sv
// XTS tweak stage wrapped around a single-block cipher core: PP = P ^ T, C = CC ^ T, T *= alpha per block.
// Optional sticky misuse flag o_err is compiled in with `define XTS_ERR_EN.
module xts_tweak_engine #(
  parameter int MAX_BLOCKS = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_tweak_valid,
  input  logic [127:0] i_tweak,
  output logic         o_tweak_ready,
  input  logic         i_data_valid,
  input  logic [127:0] i_data,
  output logic         o_data_ready,
  output logic         o_data_valid,
  output logic [127:0] o_data,
  input  logic         i_data_ready,
  output logic         o_cipher_start,
  output logic [127:0] o_cipher_data,
  input  logic [127:0] i_cipher_data,
  input  logic         i_cipher_valid,
`ifdef XTS_ERR_EN
  output logic         o_err,
`endif
  output logic         o_sector_done
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READY       = 2'd1,
    WAIT_CIPHER = 2'd2,
    OUTPUT      = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_tweak;
  logic [7:0]   r_cnt;
  logic [127:0] r_cipher_data;
  logic         r_cipher_start;
  logic [127:0] r_data;
  logic         r_data_valid;
  logic         r_sector_done;

  logic w_tweak_load;
  logic w_accept;
  logic w_result;
  logic w_handshake;
  logic w_last;

  // Multiply by alpha in GF(2^128) with the XTS reduction polynomial x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul_alpha(input logic [127:0] t);
    return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
  endfunction

  assign w_tweak_load = (r_state == IDLE) && i_tweak_valid;
  assign w_accept     = (r_state == READY) && i_data_valid;
  assign w_result     = (r_state == WAIT_CIPHER) && i_cipher_valid;
  assign w_handshake  = (r_state == OUTPUT) && r_data_valid && i_data_ready;
  assign w_last       = (r_cnt == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:        if (i_tweak_valid)  w_state_nxt = READY;
      READY:       if (i_data_valid)   w_state_nxt = WAIT_CIPHER;
      WAIT_CIPHER: if (i_cipher_valid) w_state_nxt = OUTPUT;
      OUTPUT:      if (w_handshake)    w_state_nxt = w_last ? IDLE : READY;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_tweak_ready = (r_state == IDLE);
    o_data_ready  = (r_state == READY);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tweak        <= '0;
      r_cnt          <= '0;
      r_cipher_data  <= '0;
      r_cipher_start <= 1'b0;
      r_data         <= '0;
      r_data_valid   <= 1'b0;
      r_sector_done  <= 1'b0;
    end else begin
      r_cipher_start <= w_accept;
      r_sector_done  <= w_handshake && w_last;
      if (w_tweak_load) begin
        r_tweak <= i_tweak;
        r_cnt   <= '0;
      end
      if (w_accept) begin
        r_cipher_data <= i_data ^ r_tweak;
      end
      if (w_result) begin
        r_data       <= i_cipher_data ^ r_tweak;
        r_data_valid <= 1'b1;
      end
      // Tweak advances only once the block has actually left, so backpressure never skips a step.
      if (w_handshake) begin
        r_data_valid <= 1'b0;
        r_tweak      <= gf_mul_alpha(r_tweak);
        r_cnt        <= r_cnt + 8'd1;
      end
    end
  end

`ifdef XTS_ERR_EN
  logic r_err;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_err <= 1'b0;
    end else if (((r_state == IDLE) && i_data_valid) ||
                 ((r_state != WAIT_CIPHER) && i_cipher_valid)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

  assign o_cipher_data  = r_cipher_data;
  assign o_cipher_start = r_cipher_start;
  assign o_data         = r_data;
  assign o_data_valid   = r_data_valid;
  assign o_sector_done  = r_sector_done;

endmodule

// File: tb/tb_xts_tweak_engine.sv
// Directed bench for xts_tweak_engine with MAX_BLOCKS = 4 and a cipher model CC = PP ^ 'hA5, latency 5.
module tb_xts_tweak_engine;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic         i_tweak_valid = 1'b0;
  logic [127:0] i_tweak = '0;
  logic         o_tweak_ready;
  logic         i_data_valid = 1'b0;
  logic [127:0] i_data = '0;
  logic         o_data_ready;
  logic         o_data_valid;
  logic [127:0] o_data;
  logic         i_data_ready = 1'b0;
  logic         o_cipher_start;
  logic [127:0] o_cipher_data;
  logic [127:0] i_cipher_data = '0;
  logic         i_cipher_valid = 1'b0;
  logic         o_sector_done;
`ifdef XTS_ERR_EN
  logic         o_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  xts_tweak_engine #(.MAX_BLOCKS(4)) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_tweak_valid  (i_tweak_valid),
    .i_tweak        (i_tweak),
    .o_tweak_ready  (o_tweak_ready),
    .i_data_valid   (i_data_valid),
    .i_data         (i_data),
    .o_data_ready   (o_data_ready),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .i_data_ready   (i_data_ready),
    .o_cipher_start (o_cipher_start),
    .o_cipher_data  (o_cipher_data),
    .i_cipher_data  (i_cipher_data),
    .i_cipher_valid (i_cipher_valid),
`ifdef XTS_ERR_EN
    .o_err          (o_err),
`endif
    .o_sector_done  (o_sector_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic         load;
    logic [127:0] t0;
    logic [127:0] p;
    logic [127:0] pp;
    logic [127:0] c;
    logic         done;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_tweak(input logic [127:0] t0, input string tag);
    chk({tag, " tweak_ready before load"}, o_tweak_ready, 1);
    i_tweak_valid = 1'b1;
    i_tweak       = t0;
    tick();
    i_tweak_valid = 1'b0;
    chk({tag, " data_ready after load"}, o_data_ready, 1);
    chk({tag, " tweak_ready after load"}, o_tweak_ready, 0);
  endtask

  // Accept P, check PP, then let the core model answer 5 cycles after the start strobe.
  task automatic send_and_cipher(input logic [127:0] p, input logic [127:0] pp,
                                 input logic [127:0] c, input string tag);
    logic [127:0] cap;
    i_data_valid = 1'b1;
    i_data       = p;
    tick();
    i_data_valid = 1'b0;
    chk({tag, " cipher_start"}, o_cipher_start, 1);
    chk({tag, " cipher_data"}, o_cipher_data, pp);
    cap = o_cipher_data;
    tick();
    chk({tag, " cipher_start one-shot"}, o_cipher_start, 0);
    repeat (3) tick();
    i_cipher_valid = 1'b1;
    i_cipher_data  = cap ^ 128'hA5;
    tick();
    i_cipher_valid = 1'b0;
    chk({tag, " data_valid"}, o_data_valid, 1);
    chk({tag, " data"}, o_data, c);
    chk({tag, " data_ready in OUTPUT"}, o_data_ready, 0);
  endtask

  task automatic drain(input logic done, input string tag);
    i_data_ready = 1'b1;
    tick();
    i_data_ready = 1'b0;
    chk({tag, " data_valid drop"}, o_data_valid, 0);
    chk({tag, " sector_done"}, o_sector_done, done);
    chk({tag, " tweak_ready"}, o_tweak_ready, done);
    chk({tag, " data_ready"}, o_data_ready, !done);
    if (done) begin
      tick();
      chk({tag, " sector_done pulse width"}, o_sector_done, 0);
    end
  endtask

  initial begin
    logic [127:0] held;

    vecs[0] = '{1'b1, 128'h1, 128'h0,  128'h1,  128'hA5, 1'b0};
    vecs[1] = '{1'b0, 128'h0, 128'h0,  128'h2,  128'hA5, 1'b0};
    vecs[2] = '{1'b0, 128'h0, 128'h10, 128'h14, 128'hB5, 1'b0};
    vecs[3] = '{1'b0, 128'h0, 128'hFF, 128'hF7, 128'h5A, 1'b1};
    vecs[4] = '{1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h0,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'hA5, 1'b0};
    vecs[5] = '{1'b0, 128'h0, 128'h0,  128'h87,  128'hA5, 1'b0};
    vecs[6] = '{1'b0, 128'h0, 128'h3,  128'h10D, 128'hA6, 1'b0};
    vecs[7] = '{1'b0, 128'h0, 128'h0,  128'h21C, 128'hA5, 1'b1};

    // Reset state
    repeat (2) tick();
    chk("rst tweak_ready", o_tweak_ready, 1);
    chk("rst data_ready", o_data_ready, 0);
    chk("rst data_valid", o_data_valid, 0);
    chk("rst data", o_data, 0);
    chk("rst cipher_start", o_cipher_start, 0);
    chk("rst cipher_data", o_cipher_data, 0);
    chk("rst sector_done", o_sector_done, 0);
`ifdef XTS_ERR_EN
    chk("rst err", o_err, 0);
`endif
    i_rstn = 1'b1;
    tick();

    // Two full sectors from the table
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].load) load_tweak(vecs[i].t0, tag);
      send_and_cipher(vecs[i].p, vecs[i].pp, vecs[i].c, tag);
      drain(vecs[i].done, tag);
    end

    // A block offered after the sector ended is not taken
    i_data_valid = 1'b1;
    i_data       = 128'h55;
    tick();
    tick();
    i_data_valid = 1'b0;
    chk("post-sector no start", o_cipher_start, 0);
    chk("post-sector data_ready", o_data_ready, 0);
    chk("post-sector cipher_data held", o_cipher_data, 128'h21C);
    chk("post-sector tweak_ready", o_tweak_ready, 1);

    // Ignored tweak reload and spurious core result while in READY
    load_tweak(128'h3, "sec3");
    i_tweak_valid  = 1'b1;
    i_tweak        = 128'hFF;
    i_cipher_valid = 1'b1;
    i_cipher_data  = 128'h1234;
    tick();
    i_tweak_valid  = 1'b0;
    i_cipher_valid = 1'b0;
    chk("spurious data_valid", o_data_valid, 0);
    chk("spurious data held", o_data, 128'hA5);
    chk("spurious data_ready", o_data_ready, 1);
`ifdef XTS_ERR_EN
    chk("spurious err", o_err, 1);
`endif
    send_and_cipher(128'h1, 128'h2, 128'hA4, "sec3 b0");

    // Backpressure: hold i_data_ready low for 10 cycles, with a reload attempt in the middle
    held = o_data;
    for (int k = 0; k < 10; k++) begin
      i_tweak_valid = (k == 4);
      i_tweak       = 128'hFF;
      tick();
      chk($sformatf("bp%0d valid", k), o_data_valid, 1);
      chk($sformatf("bp%0d data", k), o_data, held);
      chk($sformatf("bp%0d data_ready", k), o_data_ready, 0);
    end
    i_tweak_valid = 1'b0;
    drain(1'b0, "sec3 b0");
    send_and_cipher(128'h0, 128'h6, 128'hA5, "sec3 b1");
    drain(1'b0, "sec3 b1");

    // Reset while the core is busy
    i_data_valid = 1'b1;
    i_data       = 128'h9;
    tick();
    i_data_valid = 1'b0;
    chk("midrst start", o_cipher_start, 1);
    tick();
    i_rstn = 1'b0;
    tick();
    chk("midrst tweak_ready", o_tweak_ready, 1);
    chk("midrst data_ready", o_data_ready, 0);
    chk("midrst data_valid", o_data_valid, 0);
    chk("midrst data", o_data, 0);
    chk("midrst cipher_start", o_cipher_start, 0);
    chk("midrst cipher_data", o_cipher_data, 0);
    chk("midrst sector_done", o_sector_done, 0);
    i_rstn = 1'b1;
    tick();
    i_cipher_valid = 1'b1;
    i_cipher_data  = 128'hDEAD;
    tick();
    i_cipher_valid = 1'b0;
    tick();
    chk("late result data_valid", o_data_valid, 0);
    chk("late result data", o_data, 0);
    chk("late result tweak_ready", o_tweak_ready, 1);

    // Fresh sector after reset starts from the new tweak and a zero count
    load_tweak(128'h40, "sec4");
    for (int b = 0; b < 4; b++) begin
      logic [127:0] pp_exp;
      pp_exp = 128'h40 << b;
      send_and_cipher(128'h0, pp_exp, 128'hA5, $sformatf("sec4 b%0d", b));
      drain(b == 3, $sformatf("sec4 b%0d", b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
